dm_byte_sweep: RTL and testbench
================================

# dm_byte_sweep

Parametrised data memory for the pipelined MIPS core's MEM stage. It replaces the fixed 4096-word, word-only store with the following:
- a configurable-depth array;
- byte, halfword and word stores through byte-lane enables;
- sign- or zero-extended sub-word loads;
- misalignment detection.

After reset it clears itself with a sequential sweep engine, one word per cycle, and reports `ready` when the sweep is done.

## Interface

Parameters:
- `DEPTH_LOG2`, default 12: log2 of the word count; the array holds 2^DEPTH_LOG2 32-bit words.
- `CLR_VAL`, default 32'h0: value written to every word by the clear sweep.

Ports:
- `clk`  in  1: single clock. All state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. 0 forces the sweep engine into INIT immediately.
- `addr`  in  32: byte address. Word index is `addr[DEPTH_LOG2+1:2]`; bits above it are ignored, so addresses wrap.
- `wdata`  in  32: store data, right-aligned. Byte in `[7:0]`, half in `[15:0]`.
- `mem_wr`  in  1: store request for the current cycle.
- `size`  in  2: access size. 00 byte, 01 half, 10 word, 11 reserved.
- `sign_ext`  in  1: 1 sign-extends sub-word loads, 0 zero-extends them.
- `pc`  in  32: PC of the MEM-stage instruction. Used by trace only.
- `rdata`  out  32: load result, extended and aligned.
- `ready`  out  1: 1 once the clear sweep has finished.
- `misalign`  out  1: combinational fault flag for the current `addr`/`size`.

## Operation

State machine (two states):
- **INIT**
  - Entered asynchronously while `reset`=0; the sweep counter is held at 0.
  - After `reset` returns to 1, each rising edge writes `CLR_VAL` to word[counter] and increments the counter.
  - When the counter reaches 2^DEPTH_LOG2−1 and that word is written, the next state is RUN.
- **RUN**: normal access. Stays in RUN until `reset` is asserted.

Misalignment:
- `misalign` = 1 for (`size`=01 and `addr[0]`=1), for (`size`=10 and `addr[1:0]`≠0), or for `size`=11.
- Otherwise `misalign` = 0.
- It is evaluated in both states.

Stores (the store takes effect only when `ready`=1, `mem_wr`=1 and `misalign`=0):
- Byte store writes lane `addr[1:0]` with `wdata[7:0]`.
- Half store writes lanes {`addr[1]`*2+1, `addr[1]`*2} with `wdata[15:0]`.
- Word store writes all four lanes.
- Unselected lanes keep their contents.

Loads:
- Loads are combinational from the addressed word.
- Byte load selects lane `addr[1:0]`; half load selects the half given by `addr[1]`; both are extended to 32 bits per `sign_ext`.
- Word load returns the whole word.
- `rdata` is forced to 0 when `ready`=0 or `misalign`=1.

Stores ignored by the block:
- Stores during INIT. The sweep owns the write port.
- Misaligned stores. The pipeline consumes `misalign` to raise an AdEL/AdES exception.

## Timing

Reset values:
- `ready`=0 and state = INIT.
- `rdata`=0, because `ready`=0.
- `misalign` follows its inputs combinationally.

Clear sweep and `ready`:
- The sweep takes exactly 2^DEPTH_LOG2 rising edges after `reset` deassertion.
- `ready` rises after the edge that writes the last word; for the default this is the 4096th edge.

Loads:
- Zero-cycle combinational latency from `addr`/`size`/`sign_ext`.
- Same-address store then load in one cycle: `rdata` shows the old word until the edge, then the new word.

Stores:
- One cycle: the array updates on the rising edge where the store conditions hold.

Boundary cases:
- **Reset mid-sweep:** the counter returns to 0 asynchronously and the sweep restarts from word 0 on release.
- **Reset in RUN:** `ready` drops immediately. Contents are re-cleared by the new sweep.
- **Address wrap:** addr = 4·2^DEPTH_LOG2 aliases word 0.
- **Sweep counter:** DEPTH_LOG2 bits wide. Terminal detect uses the all-ones value, not an overflow.

## Configuration

`DM_TRACE_EN`:
- **Defined:** every accepted store prints "%d@%h: *%h <= %h" with $time, `pc`, the word-aligned byte address, and the merged 32-bit word written.
  - Ignored stores (sweep writes, misaligned, not ready) are not printed.
- **Undefined:** no trace logic is compiled and `pc` is unused. Behaviour is otherwise identical.

## Test plan

1. **Reset sweep:** DEPTH_LOG2=4, `CLR_VAL`=32'hDEADBEEF, pulse `reset` low then release.
   - `ready`=0 for 16 edges and 1 after the 16th.
   - Word loads at 0x0–0x3C all return DEADBEEF.
2. **Sub-word stores:** in RUN, word store 0x11223344 @0x8, byte store 0xAB @0x9, half store 0xCDEF @0xA.
   - Word load @0x8 returns 0xCDEFAB44.
3. **Load extension** on word 0x80FF7F01 @0x0:
   - lb @0x2, `sign_ext`=1 → 0xFFFFFFFF.
   - lbu @0x3 → 0x00000080.
   - lh @0x0 → 0x00007F01.
   - lh @0x2 → 0xFFFF80FF.
4. **Misalignment:** word store 0x12345678 @0x6 and half store @0x5.
   - `misalign`=1 for both, `rdata`=0.
   - Memory @0x4 unchanged; no trace line with `DM_TRACE_EN`.
5. **Reset mid-sweep:** assert `reset` low at sweep edge 7, release.
   - `ready` rises exactly 16 edges after the second release.
   - Stores issued during INIT do not alter memory.
6. **Wrap:** DEPTH_LOG2=4, word store 0xCAFEF00D @0x40.
   - Word load @0x0 returns 0xCAFEF00D.
   - With `DM_TRACE_EN`, the trace shows address 00000000.

Source files
------------

// File: rtl/dm_byte_sweep.sv
// Data memory for the MIPS MEM stage: byte/half/word stores via lane enables,
// extended sub-word loads, misalign flag, self-clearing sweep. Optional trace: DM_TRACE_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | sweep engine owns the write port, clears one word per edge
// ST_RUN  | normal load/store access, ready=1
module dm_byte_sweep #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] CLR_VAL    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DEPTH_LOG2-1:0]   r_cnt;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_ready;
    logic                    w_sweep_we;
    logic                    w_term;
    logic                    w_misalign;
    logic                    w_store;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [3:0]              w_be;
    logic [31:0]             w_wd_al;
    logic [31:0]             w_old;
    logic [31:0]             w_merged;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_rd;
    logic                    w_unused;

    assign w_idx  = addr[DEPTH_LOG2+1:2];
    assign w_old  = r_mem[w_idx];
    assign w_term = (r_cnt == {DEPTH_LOG2{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_term) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Sweep writes are gated by reset so a held reset never touches the array.
    always_comb begin
        w_ready    = (r_state == ST_RUN);
        w_sweep_we = (r_state == ST_INIT) && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_cnt <= '0;
        else if (w_sweep_we) r_cnt <= r_cnt + 1'b1;
    end

    always_comb begin
        case (size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = addr[0];
            2'b10:   w_misalign = |addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wd_al = wdata;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wd_al = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wd_al = {2{wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_merged[8*i +: 8] = w_wd_al[8*i +: 8];
        end
    end

    assign w_store = w_ready && mem_wr && !w_misalign;

    always_ff @(posedge clk) begin
        if (w_sweep_we)   r_mem[r_cnt] <= CLR_VAL;
        else if (w_store) r_mem[w_idx] <= w_merged;
    end

    always_comb begin
        case (addr[1:0])
            2'b00:   w_byte = w_old[7:0];
            2'b01:   w_byte = w_old[15:8];
            2'b10:   w_byte = w_old[23:16];
            default: w_byte = w_old[31:24];
        endcase
        w_half = addr[1] ? w_old[31:16] : w_old[15:0];
    end

    always_comb begin
        case (size)
            2'b00:   w_rd = {{24{sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_rd = {{16{sign_ext & w_half[15]}}, w_half};
            2'b10:   w_rd = w_old;
            default: w_rd = 32'h0;
        endcase
    end

    assign rdata    = (w_ready && !w_misalign) ? w_rd : 32'h0;
    assign ready    = w_ready;
    assign misalign = w_misalign;

    // Address bits above the word index wrap by design; pc only feeds the trace.
    assign w_unused = ^{pc, addr[31:DEPTH_LOG2+2]};

`ifdef DM_TRACE_EN
    logic [31:0] w_word_addr;
    assign w_word_addr = 32'({w_idx, 2'b00});

    always @(posedge clk) begin
        if (w_store) $display("%d@%h: *%h <= %h", $time, pc, w_word_addr, w_merged);
    end
`else
`endif

endmodule

// File: tb/tb_dm_byte_sweep.sv
// Directed self-checking bench for dm_byte_sweep (DEPTH_LOG2=4, CLR_VAL=DEADBEEF).
module tb_dm_byte_sweep;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        ready;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;
    int n_edge;

    dm_byte_sweep #(.DEPTH_LOG2(4), .CLR_VAL(32'hDEADBEEF)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .mem_wr   (mem_wr),
        .size     (size),
        .sign_ext (sign_ext),
        .pc       (pc),
        .rdata    (rdata),
        .ready    (ready),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        addr   = a;
        wdata  = d;
        size   = s;
        mem_wr = 1'b1;
        pc     = pc + 32'd4;
        tick();
        mem_wr = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic sx);
        addr     = a;
        size     = s;
        sign_ext = sx;
        #1;
    endtask

    task automatic wait_ready(input string tag, input int exp_edges);
        n_edge = 0;
        while (!ready && n_edge < 40) begin
            tick();
            n_edge++;
        end
        check_eq(tag, n_edge, exp_edges);
    endtask

    initial begin
        reset    = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        mem_wr   = 1'b0;
        size     = 2'b10;
        sign_ext = 1'b0;
        pc       = 32'h0040_0000;

        // reset state
        tick();
        tick();
        check_eq("rst_ready", {31'b0, ready}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_misalign", {31'b0, misalign}, 32'h0);
        size = 2'b11;
        #1;
        check_eq("rst_misalign_sz11", {31'b0, misalign}, 32'h1);
        size = 2'b10;

        // clear sweep
        @(negedge clk);
        reset = 1'b1;
        wait_ready("sweep_edges", 16);
        for (int i = 0; i < 16; i++) begin
            do_load(32'(i * 4), 2'b10, 1'b0);
            check_eq($sformatf("clr_w%0d", i), rdata, 32'hDEADBEEF);
        end

        // sub-word stores
        do_store(32'h8, 32'h11223344, 2'b10);
        do_load(32'h8, 2'b10, 1'b0);
        check_eq("sw_word", rdata, 32'h11223344);
        do_store(32'h9, 32'h000000AB, 2'b00);
        do_store(32'hA, 32'h0000CDEF, 2'b01);
        do_load(32'h8, 2'b10, 1'b0);
        check_eq("sw_merged", rdata, 32'hCDEFAB44);

        // load extension
        do_store(32'h0, 32'h80FF7F01, 2'b10);
        do_load(32'h2, 2'b00, 1'b1);
        check_eq("lb_2", rdata, 32'hFFFFFFFF);
        do_load(32'h3, 2'b00, 1'b0);
        check_eq("lbu_3", rdata, 32'h00000080);
        do_load(32'h1, 2'b00, 1'b1);
        check_eq("lb_1", rdata, 32'h0000007F);
        do_load(32'h0, 2'b01, 1'b1);
        check_eq("lh_0", rdata, 32'h00007F01);
        do_load(32'h2, 2'b01, 1'b1);
        check_eq("lh_2", rdata, 32'hFFFF80FF);
        do_load(32'h2, 2'b01, 1'b0);
        check_eq("lhu_2", rdata, 32'h000080FF);

        // same-cycle store then load: old word before the edge, new after
        addr = 32'h0; size = 2'b10; wdata = 32'h0BADF00D; mem_wr = 1'b1;
        #1;
        check_eq("rw_before", rdata, 32'h80FF7F01);
        tick();
        mem_wr = 1'b0;
        check_eq("rw_after", rdata, 32'h0BADF00D);

        // misalignment
        do_store(32'h4, 32'h55667788, 2'b10);
        addr = 32'h6; size = 2'b10; wdata = 32'h12345678; mem_wr = 1'b1;
        #1;
        check_eq("mis_word_flag", {31'b0, misalign}, 32'h1);
        check_eq("mis_word_rdata", rdata, 32'h0);
        tick();
        addr = 32'h5; size = 2'b01;
        #1;
        check_eq("mis_half_flag", {31'b0, misalign}, 32'h1);
        check_eq("mis_half_rdata", rdata, 32'h0);
        tick();
        mem_wr = 1'b0;
        do_load(32'h6, 2'b01, 1'b0);
        check_eq("half_6_aligned", {31'b0, misalign}, 32'h0);
        do_load(32'h4, 2'b10, 1'b0);
        check_eq("mis_mem_kept", rdata, 32'h55667788);

        // address wrap
        do_store(32'h40, 32'hCAFEF00D, 2'b10);
        do_load(32'h0, 2'b10, 1'b0);
        check_eq("wrap_w0", rdata, 32'hCAFEF00D);

        // reset in RUN, then reset mid-sweep with stores held during INIT
        reset = 1'b0;
        #1;
        check_eq("run_rst_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("mid_ready", {31'b0, ready}, 32'h0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        addr = 32'h0; size = 2'b10; wdata = 32'h12345678; mem_wr = 1'b1;
        wait_ready("resweep_edges", 16);
        mem_wr = 1'b0;
        do_load(32'h0, 2'b10, 1'b0);
        check_eq("resweep_w0", rdata, 32'hDEADBEEF);
        do_load(32'h8, 2'b10, 1'b0);
        check_eq("resweep_w2", rdata, 32'hDEADBEEF);
        do_load(32'h3C, 2'b10, 1'b0);
        check_eq("resweep_w15", rdata, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
